ahb_slave_if: RTL and testbench
===============================

# ahb_slave_if

AHB-side front end of the AHB-to-APB bridge, directly upstream of `APB_FSM`. It qualifies AHB transfers, decodes the target APB slave and pipelines address, data and direction into the registered form the FSM consumes (`valid`, `Haddr1/2`, `Hwdata1/2`, `Hwritereg`, `tempselx`). It also owns the AHB response:
- two-cycle ERROR for unmapped addresses;
- merged `Hreadyout` back to the master;
- saturating transfer/error counters for debug.

## Interface
Parameters:
- `SLV0_BASE`, default 6'b100000: `Haddr[31:26]` value selecting slave 0.
- `SLV1_BASE`, default 6'b100001: `Haddr[31:26]` value selecting slave 1.
- `SLV2_BASE`, default 6'b100010: `Haddr[31:26]` value selecting slave 2.
- `CNT_W`, default 16: width of debug counters.

Ports:
- `clk`  in  1  single bridge clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Hwrite`  in  1  AHB direction, 1 = write.
- `Hreadyin`  in  1  AHB bus ready (phase advance).
- `Htrans`  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Haddr`  in  32  AHB address.
- `Hwdata`  in  32  AHB write data (data phase).
- `Prdata`  in  32  APB read data.
- `Hreadyout_fsm`  in  1  ready from `APB_FSM`.
- `valid`  out  1  qualified, mapped transfer (combinational).
- `tempselx`  out  3  one-hot slave select (registered).
- `Haddr1`, `Haddr2`  out  32  address pipeline stages 1 and 2.
- `Hwdata1`, `Hwdata2`  out  32  data pipeline stages 1 and 2.
- `Hwritereg`  out  1  registered `Hwrite`.
- `Hreadyout`  out  1  ready to the AHB master.
- `Hresp`  out  2  00 OKAY, 01 ERROR.
- `Hrdata`  out  32  equals `Prdata`.
- `xfer_cnt`  out  CNT_W  accepted transfers, saturating.
- `err_cnt`  out  CNT_W  ERROR responses issued, saturating.

## Operation
- `active` = `Hreadyin` & `Htrans[1]` (NONSEQ or SEQ). BUSY and IDLE are never active.
- `mapped` = `Haddr[31:26]` equals one of the three bases.
- `valid` = `active` & `mapped` & (`err_state` == OK).
- Decode is `Haddr[31:26]` == `SLVn_BASE` → bit n of the one-hot select. No match gives 000.
- Pipeline registers load only when `Hreadyin` = 1, and hold otherwise:
  - `Haddr1` ← `Haddr`, `Haddr2` ← `Haddr1`;
  - `Hwdata1` ← `Hwdata`, `Hwdata2` ← `Hwdata1`;
  - `Hwritereg` ← `Hwrite`, `tempselx` ← decode.
- Error FSM, states OK, ERR1, ERR2:
  - OK → ERR1 when `active` & !`mapped`.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → OK unconditionally.
- Outputs per error state:
  - OK: `Hresp` = 00, `Hreadyout` = `Hreadyout_fsm`.
  - ERR1: `Hresp` = 01, `Hreadyout` = 0.
  - ERR2: `Hresp` = 01, `Hreadyout` = 1.
- Transfers are not accepted while in ERR1 or ERR2; `valid` is forced to 0.
- `xfer_cnt` increments on each cycle with `valid` = 1. `err_cnt` increments on each OK → ERR1 transition. Both saturate at all-ones and never wrap.

## Timing
- Reset (`rst` low, asynchronous): all pipeline registers 0, `tempselx` = 000, `Hwritereg` = 0, error state OK, counters 0.
- Outputs during reset: `Hreadyout` follows `Hreadyout_fsm`, `Hresp` = 00, `valid` = 0.
- `valid` has zero latency: it is combinational from the address phase.
- `Haddr1`, `tempselx` and `Hwritereg` appear 1 cycle after the address phase; `Haddr2` after 2 cycles.
- `Hwdata1` appears 1 cycle after the data phase; `Hwdata2` 1 cycle after that.
- An unmapped transfer gets ERROR on cycles N+1 (`Hreadyout` = 0) and N+2 (`Hreadyout` = 1), where N is its address phase. A new address can be accepted again on the cycle after ERR2.
- Unmapped address with `Hreadyin` = 0: no transition and no count.
- `rst` deasserting mid-burst: the first `valid` is the first qualified address phase after release. No partial state survives.
- Counters at saturation with a simultaneous event: value holds.

## Structure
- Shared package `ahb_apb_pkg` holds:
  - `htrans_t` enum (IDLE/BUSY/NONSEQ/SEQ);
  - `hresp_t` (OKAY/ERROR);
  - `err_state_t` (OK/ERR1/ERR2);
  - the three default slave base constants.
  `APB_FSM` state encodings also move here.
- One natural sub-module: `sat_counter` (width-parameterised, increment enable, saturate), instantiated twice.

## Test plan
- Write NONSEQ, `Haddr` = 0x8000_0010, `Hwdata` = 0xA5A5_0001 next cycle → `valid` = 1 that cycle; `Haddr1` = 0x8000_0010, `tempselx` = 001, `Hwritereg` = 1 one cycle later; `Hwdata1` = 0xA5A5_0001 the cycle after.
- Read SEQ burst of 4 to 0x8800_0000..0x8800_000C → `tempselx` = 100; `Haddr2` lags `Haddr` by 2; `xfer_cnt` = 4.
- `Htrans` = BUSY at mapped 0x8400_0000 → `valid` = 0, `xfer_cnt` unchanged. Then NONSEQ → `tempselx` = 010.
- NONSEQ to unmapped 0x0000_1000 → next cycle `Hresp` = 01 with `Hreadyout` = 0; following cycle `Hresp` = 01 with `Hreadyout` = 1; then `Hresp` = 00; `err_cnt` = 1. A mapped address driven during ERR1 gives `valid` = 0.
- `Hreadyin` = 0 for 3 cycles with a mapped address held → pipeline registers frozen, `valid` = 0.
- Preload counters to 0xFFFE, 3 valid transfers → `xfer_cnt` = 0xFFFF, no wrap. Assert `rst` = 0 mid-burst → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package ahb_apb_pkg;

    // AHB transfer type
    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    // AHB response
    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01
    } hresp_t;

    // Two-cycle ERROR response sequencer
    typedef enum logic [1:0] {
        ES_OK   = 2'b00,
        ES_ERR1 = 2'b01,
        ES_ERR2 = 2'b10
    } err_state_t;

    // APB_FSM state encodings
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_t;

    // Default Haddr[31:26] region for each APB slave
    localparam logic [5:0] SLV0_BASE_DEF = 6'b100000;
    localparam logic [5:0] SLV1_BASE_DEF = 6'b100001;
    localparam logic [5:0] SLV2_BASE_DEF = 6'b100010;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared by async active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: qualifies transfers, decodes the
// APB slave, pipelines address/data/direction for APB_FSM, and generates the
// two-cycle ERROR response for unmapped addresses.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter logic [5:0]  SLV0_BASE = SLV0_BASE_DEF,
    parameter logic [5:0]  SLV1_BASE = SLV1_BASE_DEF,
    parameter logic [5:0]  SLV2_BASE = SLV2_BASE_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Hwrite,
    input  logic             Hreadyin,
    input  logic [1:0]       Htrans,
    input  logic [31:0]      Haddr,
    input  logic [31:0]      Hwdata,
    input  logic [31:0]      Prdata,
    input  logic             Hreadyout_fsm,
    output logic             valid,
    output logic [2:0]       tempselx,
    output logic [31:0]      Haddr1,
    output logic [31:0]      Haddr2,
    output logic [31:0]      Hwdata1,
    output logic [31:0]      Hwdata2,
    output logic             Hwritereg,
    output logic             Hreadyout,
    output logic [1:0]       Hresp,
    output logic [31:0]      Hrdata,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    htrans_t    trans;
    logic       active;
    logic       mapped;
    logic       err_evt;
    logic [2:0] sel_dec;

    err_state_t err_state_d, err_state_q;
    hresp_t     hresp_q;

    logic [31:0] haddr1_d, haddr1_q, haddr2_d, haddr2_q;
    logic [31:0] hwdata1_d, hwdata1_q, hwdata2_d, hwdata2_q;
    logic        hwritereg_d, hwritereg_q;
    logic [2:0]  tempselx_d, tempselx_q;

    assign trans  = htrans_t'(Htrans);
    assign active = Hreadyin && ((trans == HT_NONSEQ) || (trans == HT_SEQ));

    // One-hot slave decode from the top address bits
    always_comb begin
        sel_dec    = '0;
        sel_dec[0] = (Haddr[31:26] == SLV0_BASE);
        sel_dec[1] = (Haddr[31:26] == SLV1_BASE);
        sel_dec[2] = (Haddr[31:26] == SLV2_BASE);
    end

    assign mapped = |sel_dec;
    // Gated by rst so valid reads 0 while reset is held, whatever the bus does
    assign valid   = rst && active && mapped && (err_state_q == ES_OK);
    assign err_evt = (err_state_q == ES_OK) && active && !mapped;

    // Error sequencer next state
    always_comb begin
        err_state_d = err_state_q;
        case (err_state_q)
            ES_OK:   if (err_evt) err_state_d = ES_ERR1;
            ES_ERR1: err_state_d = ES_ERR2;
            ES_ERR2: err_state_d = ES_OK;
            default: err_state_d = ES_OK;
        endcase
    end

    // Error state and registered Hresp
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_state_q <= ES_OK;
            hresp_q     <= HR_OKAY;
        end else begin
            err_state_q <= err_state_d;
            hresp_q     <= (err_state_d == ES_OK) ? HR_OKAY : HR_ERROR;
        end
    end

    // Pipeline next values: advance only when the bus is ready
    always_comb begin
        haddr1_d    = haddr1_q;
        haddr2_d    = haddr2_q;
        hwdata1_d   = hwdata1_q;
        hwdata2_d   = hwdata2_q;
        hwritereg_d = hwritereg_q;
        tempselx_d  = tempselx_q;
        if (Hreadyin) begin
            haddr1_d    = Haddr;
            haddr2_d    = haddr1_q;
            hwdata1_d   = Hwdata;
            hwdata2_d   = hwdata1_q;
            hwritereg_d = Hwrite;
            tempselx_d  = sel_dec;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            haddr1_q    <= '0;
            haddr2_q    <= '0;
            hwdata1_q   <= '0;
            hwdata2_q   <= '0;
            hwritereg_q <= 1'b0;
            tempselx_q  <= '0;
        end else begin
            haddr1_q    <= haddr1_d;
            haddr2_q    <= haddr2_d;
            hwdata1_q   <= hwdata1_d;
            hwdata2_q   <= hwdata2_d;
            hwritereg_q <= hwritereg_d;
            tempselx_q  <= tempselx_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_xfer_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (valid),
        .count (xfer_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_evt),
        .count (err_cnt)
    );

    assign Haddr1    = haddr1_q;
    assign Haddr2    = haddr2_q;
    assign Hwdata1   = hwdata1_q;
    assign Hwdata2   = hwdata2_q;
    assign Hwritereg = hwritereg_q;
    assign tempselx  = tempselx_q;
    assign Hresp     = hresp_q;
    assign Hrdata    = Prdata;
    assign Hreadyout = (err_state_q == ES_OK) ? Hreadyout_fsm : (err_state_q == ES_ERR2);

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_ahb_slave_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Hwrite = 1'b0, Hreadyin = 1'b0, Hreadyout_fsm = 1'b0;
    logic [1:0]  Htrans = 2'b00;
    logic [31:0] Haddr = '0, Hwdata = '0, Prdata = '0;

    logic        valid, Hwritereg, Hreadyout;
    logic [2:0]  tempselx;
    logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
    logic [1:0]  Hresp;
    logic [15:0] xfer_cnt, err_cnt;

    // Second instance with narrow counters so saturation is reachable
    logic        s_valid, s_Hwritereg, s_Hreadyout;
    logic [2:0]  s_tempselx;
    logic [31:0] s_Haddr1, s_Haddr2, s_Hwdata1, s_Hwdata2, s_Hrdata;
    logic [1:0]  s_Hresp;
    logic [3:0]  s_xfer_cnt, s_err_cnt;

    ahb_slave_if dut (
        .clk(clk), .rst(rst), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
        .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .Hreadyout_fsm(Hreadyout_fsm),
        .valid(valid), .tempselx(tempselx), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
        .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
    );

    ahb_slave_if #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
        .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .Hreadyout_fsm(Hreadyout_fsm),
        .valid(s_valid), .tempselx(s_tempselx), .Haddr1(s_Haddr1), .Haddr2(s_Haddr2),
        .Hwdata1(s_Hwdata1), .Hwdata2(s_Hwdata2), .Hwritereg(s_Hwritereg),
        .Hreadyout(s_Hreadyout), .Hresp(s_Hresp), .Hrdata(s_Hrdata),
        .xfer_cnt(s_xfer_cnt), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [5:0]  bases [3] = '{6'b100000, 6'b100001, 6'b100010};
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w;
    logic [2:0]  m_sel;
    int          m_left;            // remaining ERROR-response cycles
    int unsigned m_xfer, m_err, m_xfer_s, m_err_s;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] slave_of(input logic [31:0] a);
        logic [2:0] s = '0;
        for (int i = 0; i < 3; i++) if (a[31:26] == bases[i]) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic exp_valid();
        return rst && Hreadyin && Htrans[1] && (slave_of(Haddr) != 3'b000) && (m_left == 0);
    endfunction

    task automatic model_reset();
        m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w = 1'b0; m_sel = '0;
        m_left = 0; m_xfer = 0; m_err = 0; m_xfer_s = 0; m_err_s = 0;
    endtask

    // Advance the model by one rising edge using the inputs the DUT just sampled
    task automatic model_step();
        logic act, mp;
        if (!rst) begin
            model_reset();
            return;
        end
        act = Hreadyin && Htrans[1];
        mp  = (slave_of(Haddr) != 3'b000);
        if (exp_valid()) begin
            if (m_xfer < 65535) m_xfer++;
            if (m_xfer_s < 15) m_xfer_s++;
        end
        if (m_left > 0) m_left--;
        else if (act && !mp) begin
            m_left = 2;
            if (m_err < 65535) m_err++;
            if (m_err_s < 15) m_err_s++;
        end
        if (Hreadyin) begin
            m_a2 = m_a1; m_a1 = Haddr; m_d2 = m_d1; m_d1 = Hwdata;
            m_w = Hwrite; m_sel = slave_of(Haddr);
        end
    endtask

    task automatic compare_all();
        check_eq("valid", valid, exp_valid());
        check_eq("hresp", Hresp, (m_left > 0) ? 2'b01 : 2'b00);
        check_eq("hreadyout", Hreadyout, (m_left == 2) ? 1'b0 : (m_left == 1) ? 1'b1 : Hreadyout_fsm);
        check_eq("hrdata", Hrdata, Prdata);
        check_eq("haddr1", Haddr1, m_a1);
        check_eq("haddr2", Haddr2, m_a2);
        check_eq("hwdata1", Hwdata1, m_d1);
        check_eq("hwdata2", Hwdata2, m_d2);
        check_eq("hwritereg", Hwritereg, m_w);
        check_eq("tempselx", tempselx, m_sel);
        check_eq("xfer_cnt", xfer_cnt, m_xfer);
        check_eq("err_cnt", err_cnt, m_err);
        check_eq("s_xfer_cnt", s_xfer_cnt, m_xfer_s);
        check_eq("s_err_cnt", s_err_cnt, m_err_s);
    endtask

    // Drive one bus cycle and compare at the falling edge
    task automatic apply(input logic w, input logic rdy, input logic [1:0] tr,
                         input logic [31:0] a, input logic [31:0] d);
        Hwrite = w; Hreadyin = rdy; Htrans = tr; Haddr = a; Hwdata = d;
        Prdata = $urandom;
        Hreadyout_fsm = 1'($urandom);
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [5:0] top;
        int unsigned pick;
        model_reset();

        // Reset held with a qualifying transfer on the bus
        Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h8000_0000; Hreadyout_fsm = 1'b1;
        @(negedge clk);
        compare_all();
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_ready", Hreadyout, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Single write
        apply(1'b1, 1'b1, 2'b10, 32'h8000_0010, 32'h0);
        check_eq("wr_valid", valid, 1'b1);
        advance();
        apply(1'b0, 1'b1, 2'b00, 32'h0, 32'hA5A5_0001);
        check_eq("wr_haddr1", Haddr1, 32'h8000_0010);
        check_eq("wr_sel", tempselx, 3'b001);
        check_eq("wr_dir", Hwritereg, 1'b1);
        advance();
        apply(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        check_eq("wr_hwdata1", Hwdata1, 32'hA5A5_0001);
        advance();

        // Read burst of 4 to slave 2
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h8800_0000 + 32'(4 * i), 32'h0);
            advance();
        end
        apply(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        check_eq("burst_sel", tempselx, 3'b100);
        check_eq("burst_haddr2", Haddr2, 32'h8800_0008);
        check_eq("burst_cnt", xfer_cnt, 16'd5);
        advance();

        // BUSY is never accepted; a following NONSEQ is
        apply(1'b0, 1'b1, 2'b01, 32'h8400_0000, 32'h0);
        check_eq("busy_valid", valid, 1'b0);
        advance();
        apply(1'b0, 1'b1, 2'b10, 32'h8400_0000, 32'h0);
        advance();
        apply(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        check_eq("busy_cnt", xfer_cnt, 16'd6);
        check_eq("nonseq_sel", tempselx, 3'b010);
        advance();

        // Unmapped address: two-cycle ERROR, mapped address ignored during ERR1
        apply(1'b0, 1'b1, 2'b10, 32'h0000_1000, 32'h0);
        advance();
        apply(1'b0, 1'b1, 2'b10, 32'h8400_0000, 32'h0);
        check_eq("err1_resp", Hresp, 2'b01);
        check_eq("err1_ready", Hreadyout, 1'b0);
        check_eq("err1_valid", valid, 1'b0);
        advance();
        apply(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        check_eq("err2_resp", Hresp, 2'b01);
        check_eq("err2_ready", Hreadyout, 1'b1);
        advance();
        apply(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        check_eq("err_done_resp", Hresp, 2'b00);
        check_eq("err_cnt_one", err_cnt, 16'd1);
        advance();

        // Bus stalled: nothing moves, nothing counted
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 2'b10, 32'h8000_0100, 32'h1234_5678);
            check_eq("stall_valid", valid, 1'b0);
            check_eq("stall_haddr1", Haddr1, 32'h0);
            advance();
        end
        apply(1'b0, 1'b0, 2'b10, 32'h0000_2000, 32'h0);
        advance();
        apply(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        check_eq("stall_unmapped_resp", Hresp, 2'b00);
        advance();

        // Randomized traffic with one asynchronous reset mid-run
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                #1 rst = 1'b0;
                #1;
                model_reset();
                check_eq("midrst_valid", valid, 1'b0);
                check_eq("midrst_resp", Hresp, 2'b00);
                check_eq("midrst_ready", Hreadyout, Hreadyout_fsm);
                check_eq("midrst_haddr1", Haddr1, 32'h0);
                check_eq("midrst_xfer", xfer_cnt, 16'd0);
                @(posedge clk); @(posedge clk); #1;
                rst = 1'b1;
            end
            pick = $urandom_range(0, 3);
            top  = (pick < 3) ? bases[pick] : 6'($urandom);
            apply(1'($urandom), ($urandom_range(0, 9) < 8), 2'($urandom),
                  {top, 26'($urandom)}, $urandom);
            advance();
        end

        apply(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        check_eq("sat_xfer", s_xfer_cnt, 4'hF);
        check_eq("sat_err", s_err_cnt, 4'hF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
